// File: rtl/ni_flit_ejector_pkg.sv
// Shared widths, flit record types and FSM encodings for the NI flit ejector.
// Used by the VC FIFOs, the out-stream interface and the ejector top.
package ni_flit_ejector_pkg;

  localparam int V     = 4;
  localparam int B     = 4;
  localparam int FPAY  = 32;
  localparam int VW    = 2;
  localparam int CRDTW = 4;
  localparam int PTRW  = (B > 1) ? $clog2(B) : 1;

  localparam logic [CRDTW-1:0] CRDT_INIT = CRDTW'(B);

  typedef struct packed {
    logic            hdr;
    logic            tail;
    logic [FPAY-1:0] payload;
  } flit_t;

  typedef struct packed {
    logic [VW-1:0]   vc;
    logic            hdr;
    logic            tail;
    logic [FPAY-1:0] payload;
  } ej_out_t;

  typedef enum logic {FRM_IDLE, FRM_IN_PCK} frm_state_e;
  typedef enum logic {ARB_FREE, ARB_LOCKED} arb_state_e;

  function automatic logic [VW-1:0] onehot_to_bin(input logic [V-1:0] oh);
    logic [VW-1:0] b;
    b = '0;
    for (int i = 0; i < V; i++)
      if (oh[i]) b = b | VW'(i);
    return b;
  endfunction

endpackage

// File: rtl/ni_flit_ejector_if.sv
// Packet-atomic ready/valid stream from the ejector to the local core.
interface ni_flit_ejector_if;
  import ni_flit_ejector_pkg::*;

  logic            out_valid;
  logic            out_ready;
  logic [VW-1:0]   out_vc;
  logic            out_hdr;
  logic            out_tail;
  logic [FPAY-1:0] out_payload;

  modport master (output out_valid, out_vc, out_hdr, out_tail, out_payload,
                  input  out_ready);
  modport slave  (input  out_valid, out_vc, out_hdr, out_tail, out_payload,
                  output out_ready);
endinterface

// File: rtl/ni_ejector_vc_fifo.sv
// Single-VC flit FIFO of depth B with occupancy count and a registered
// overflow pulse; a write into a full FIFO is dropped even if a read coincides.
module ni_ejector_vc_fifo
  import ni_flit_ejector_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  wr_en,
  input  logic  rd_en,
  input  flit_t din,
  output flit_t dout,
  output logic  empty,
  output logic  full,
  output logic  ovf
);

  flit_t            mem [B];
  logic [PTRW-1:0]  wr_ptr, rd_ptr;
  logic [CRDTW-1:0] count;
  logic             wr_ok, rd_ok;

  function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
    return (p == PTRW'(B - 1)) ? '0 : p + PTRW'(1);
  endfunction

  assign full  = (count == CRDT_INIT);
  assign empty = (count == '0);
  assign wr_ok = wr_en & ~full;
  assign rd_ok = rd_en & ~empty;
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= ptr_inc(wr_ptr);
      if (rd_ok) rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CRDTW'(wr_ok) - CRDTW'(rd_ok);
      ovf   <= wr_en & full;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/ni_flit_ejector.sv
// NoC NI receive endpoint: per-VC buffering, credit return and round-robin,
// packet-atomic delivery to the core.
//   state      | meaning
//   ARB_FREE   | pick next VC with a header at its head, round-robin from rr_ptr
//   ARB_LOCKED | serve only lock_vc until its tail is handed over
module ni_flit_ejector
  import ni_flit_ejector_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flit_in_wr,
  input  logic [V-1:0]         flit_in_vc,
  input  logic                 flit_in_hdr,
  input  logic                 flit_in_tail,
  input  logic [FPAY-1:0]      flit_in_payload,
  output logic [V-1:0]         credit_out,
  output logic [V*CRDTW-1:0]   credit_init_val_out,
  ni_flit_ejector_if.master    ej,
  output logic                 ovf_err,
  output logic                 proto_err
);

  flit_t         head [V];
  logic [V-1:0]  empty, full, ovf_pulse, hdr_vec, wr_vec, rd_vec;
  logic          vc_ok, frm_err, ovf_q, hs;
  frm_state_e    frm_q [V];
  frm_state_e    frm_d [V];
  arb_state_e    arb_q, arb_d;
  logic [VW-1:0] lock_q, lock_d, ptr_q, ptr_d, free_vc, sel_vc, idx;
  logic          free_found, sel_valid;
  flit_t         sel_flit;

  assign credit_init_val_out = {V{CRDT_INIT}};
  assign vc_ok  = $onehot(flit_in_vc);
  assign wr_vec = (flit_in_wr && vc_ok) ? flit_in_vc : '0;

  for (genvar g = 0; g < V; g++) begin : g_vc
    ni_ejector_vc_fifo u_fifo (
      .clk   (clk),
      .reset (reset),
      .wr_en (wr_vec[g]),
      .rd_en (rd_vec[g]),
      .din   ('{hdr: flit_in_hdr, tail: flit_in_tail, payload: flit_in_payload}),
      .dout  (head[g]),
      .empty (empty[g]),
      .full  (full[g]),
      .ovf   (ovf_pulse[g])
    );
    assign hdr_vec[g] = head[g].hdr;
  end

  // Framing tracks only flits that actually land in a FIFO.
  always_comb begin
    frm_err = 1'b0;
    for (int v = 0; v < V; v++) begin
      frm_d[v] = frm_q[v];
      if (wr_vec[v] && !full[v]) begin
        if ((frm_q[v] == FRM_IDLE && !flit_in_hdr) || (frm_q[v] == FRM_IN_PCK && flit_in_hdr))
          frm_err = 1'b1;
        if (flit_in_tail)     frm_d[v] = FRM_IDLE;
        else if (flit_in_hdr) frm_d[v] = FRM_IN_PCK;
      end
    end
  end

  // Descending scan so the lowest offset from the pointer wins.
  always_comb begin
    free_found = 1'b0;
    free_vc    = '0;
    idx        = '0;
    for (int i = V - 1; i >= 0; i--) begin
      idx = ptr_q + VW'(i);
      if (!empty[idx] && hdr_vec[idx]) begin
        free_found = 1'b1;
        free_vc    = idx;
      end
    end
  end

  assign sel_vc    = (arb_q == ARB_LOCKED) ? lock_q : free_vc;
  assign sel_valid = (arb_q == ARB_LOCKED) ? ~empty[lock_q] : free_found;
  assign sel_flit  = head[sel_vc];
  assign hs        = sel_valid & ej.out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      arb_q  <= ARB_FREE;
      lock_q <= '0;
      ptr_q  <= '0;
    end else begin
      arb_q  <= arb_d;
      lock_q <= lock_d;
      ptr_q  <= ptr_d;
    end
  end

  always_comb begin
    arb_d  = arb_q;
    lock_d = lock_q;
    ptr_d  = ptr_q;
    if (hs) begin
      if (arb_q == ARB_FREE) begin
        ptr_d = sel_vc + VW'(1);
        if (!sel_flit.tail) begin
          arb_d  = ARB_LOCKED;
          lock_d = sel_vc;
        end
      end else if (sel_flit.tail) begin
        arb_d = ARB_FREE;
        ptr_d = lock_q + VW'(1);
      end
    end
  end

  always_comb begin
    ej.out_valid   = sel_valid;
    ej.out_vc      = sel_valid ? sel_vc : '0;
    ej.out_hdr     = sel_valid & sel_flit.hdr;
    ej.out_tail    = sel_valid & sel_flit.tail;
    ej.out_payload = sel_valid ? sel_flit.payload : '0;
    rd_vec         = '0;
    if (hs) rd_vec[sel_vc] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int v = 0; v < V; v++) frm_q[v] <= FRM_IDLE;
      credit_out <= '0;
      proto_err  <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      for (int v = 0; v < V; v++) frm_q[v] <= frm_d[v];
      credit_out <= rd_vec;
      proto_err  <= proto_err | frm_err | (flit_in_wr & ~vc_ok);
      ovf_q      <= ovf_q | (|ovf_pulse);
    end
  end

  assign ovf_err = ovf_q | (|ovf_pulse);

endmodule

// File: tb/tb_ni_flit_ejector.sv
// Randomized and directed bench for ni_flit_ejector against a queue-based
// model of per-VC buffering, round-robin packet-atomic delivery and credits.
module tb_ni_flit_ejector;
  import ni_flit_ejector_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic                 flit_in_wr = 1'b0;
  logic [V-1:0]         flit_in_vc = '0;
  logic                 flit_in_hdr = 1'b0;
  logic                 flit_in_tail = 1'b0;
  logic [FPAY-1:0]      flit_in_payload = '0;
  logic [V-1:0]         credit_out;
  logic [V*CRDTW-1:0]   credit_init_val_out;
  logic                 ovf_err, proto_err;

  ni_flit_ejector_if ej();

  ni_flit_ejector dut (
    .clk                 (clk),
    .reset               (reset),
    .flit_in_wr          (flit_in_wr),
    .flit_in_vc          (flit_in_vc),
    .flit_in_hdr         (flit_in_hdr),
    .flit_in_tail        (flit_in_tail),
    .flit_in_payload     (flit_in_payload),
    .credit_out          (credit_out),
    .credit_init_val_out (credit_init_val_out),
    .ej                  (ej.master),
    .ovf_err             (ovf_err),
    .proto_err           (proto_err)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one queue per VC, a lock flag and a round-robin pointer.
  flit_t          mq [V][$];
  bit             m_locked;
  int             m_lock_vc, m_ptr;
  bit             m_in_pck [V];
  bit             m_proto, m_ovf;
  logic [V-1:0]   m_credit;
  int             log_vc [$];
  logic [FPAY-1:0] log_pay [$];

  function automatic void m_present(output bit v, output int vc);
    v  = 1'b0;
    vc = 0;
    if (m_locked) begin
      vc = m_lock_vc;
      v  = (mq[vc].size() > 0);
    end else begin
      for (int i = 0; i < V; i++) begin
        int c;
        c = (m_ptr + i) % V;
        if (!v && mq[c].size() > 0 && mq[c][0].hdr) begin
          v  = 1'b1;
          vc = c;
        end
      end
    end
  endfunction

  bit    mp_v, mp_push;
  int    mp_vc, mp_w;
  flit_t mp_f;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int v = 0; v < V; v++) begin
        mq[v].delete();
        m_in_pck[v] = 1'b0;
      end
      m_locked = 1'b0; m_lock_vc = 0; m_ptr = 0;
      m_proto = 1'b0; m_ovf = 1'b0; m_credit = '0;
      log_vc.delete(); log_pay.delete();
    end else begin
      m_present(mp_v, mp_vc);
      m_credit = '0;
      mp_push  = 1'b0;
      mp_w     = 0;
      if (flit_in_wr) begin
        if ($countones(flit_in_vc) != 1) m_proto = 1'b1;
        else begin
          for (int v = 0; v < V; v++) if (flit_in_vc[v]) mp_w = v;
          if (mq[mp_w].size() >= B) m_ovf = 1'b1;
          else begin
            mp_push = 1'b1;
            if (m_in_pck[mp_w] == flit_in_hdr) m_proto = 1'b1;
            if (flit_in_tail) m_in_pck[mp_w] = 1'b0;
            else if (flit_in_hdr) m_in_pck[mp_w] = 1'b1;
          end
        end
      end
      if (mp_v && ej.out_ready) begin
        mp_f = mq[mp_vc].pop_front();
        log_vc.push_back(mp_vc);
        log_pay.push_back(mp_f.payload);
        m_credit[mp_vc] = 1'b1;
        if (!m_locked) begin
          m_ptr = (mp_vc + 1) % V;
          if (!mp_f.tail) begin m_locked = 1'b1; m_lock_vc = mp_vc; end
        end else if (mp_f.tail) begin
          m_locked = 1'b0;
          m_ptr = (mp_vc + 1) % V;
        end
      end
      if (mp_push)
        mq[mp_w].push_back('{hdr: flit_in_hdr, tail: flit_in_tail, payload: flit_in_payload});
    end
  end

  bit cp_v;
  int cp_vc;
  int dut_crd_cnt = 0;

  always @(negedge clk) begin
    m_present(cp_v, cp_vc);
    chk("out_valid", ej.out_valid, cp_v);
    if (cp_v) begin
      chk("out_vc", ej.out_vc, cp_vc);
      chk("out_hdr", ej.out_hdr, mq[cp_vc][0].hdr);
      chk("out_tail", ej.out_tail, mq[cp_vc][0].tail);
      chk("out_payload", ej.out_payload, mq[cp_vc][0].payload);
    end else begin
      chk("idle_payload", ej.out_payload, 0);
    end
    chk("credit_out", credit_out, m_credit);
    chk("ovf_err", ovf_err, m_ovf);
    chk("proto_err", proto_err, m_proto);
    if (reset) dut_crd_cnt += $countones(credit_out);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int v, input bit h, input bit t, input logic [FPAY-1:0] p);
    flit_in_wr      = 1'b1;
    flit_in_vc      = V'(1 << v);
    flit_in_hdr     = h;
    flit_in_tail    = t;
    flit_in_payload = p;
    cyc();
    flit_in_wr = 1'b0;
  endtask

  task automatic do_reset();
    flit_in_wr   = 1'b0;
    ej.out_ready = 1'b0;
    reset = 1'b0;
    cyc(); cyc();
    reset = 1'b1;
    cyc();
    dut_crd_cnt = 0;
  endtask

  int s_cred [V];
  int s_rem [V];
  int sent;

  // One stimulus cycle of legal, credit-respecting traffic.
  task automatic rnd_cycle(input bit allow_new);
    int v;
    bit go;
    go = 1'b0;
    v  = 0;
    if (allow_new) begin
      ej.out_ready = ($urandom % 4) != 0;
      v  = $urandom % V;
      go = (s_cred[v] > 0) && (($urandom % 3) != 0);
    end else begin
      ej.out_ready = 1'b1;
      for (int i = V - 1; i >= 0; i--)
        if (s_rem[i] > 0 && s_cred[i] > 0) begin go = 1'b1; v = i; end
    end
    if (go) begin
      flit_in_hdr = 1'b0;
      if (s_rem[v] == 0) begin
        s_rem[v] = $urandom_range(1, 4);
        flit_in_hdr = 1'b1;
      end
      flit_in_tail    = (s_rem[v] == 1);
      flit_in_payload = $urandom;
      flit_in_vc      = V'(1 << v);
      flit_in_wr      = 1'b1;
      s_rem[v]--;
      s_cred[v]--;
      sent++;
    end else begin
      flit_in_wr = 1'b0;
    end
    cyc();
    flit_in_wr = 1'b0;
    for (int i = 0; i < V; i++) if (m_credit[i]) s_cred[i]++;
  endtask

  initial begin
    ej.out_ready = 1'b0;
    do_reset();
    chk("credit_init", credit_init_val_out, 16'h4444);
    chk("rst_valid", ej.out_valid, 0);
    chk("rst_credit", credit_out, 0);

    // Randomized legal traffic, then drain all open packets.
    for (int v = 0; v < V; v++) begin s_cred[v] = B; s_rem[v] = 0; end
    sent = 0;
    for (int n = 0; n < 3000; n++) rnd_cycle(1'b1);
    for (int n = 0; n < 200; n++) rnd_cycle(1'b0);
    repeat (10) cyc();
    chk("rnd_delivered", log_vc.size(), sent);
    chk("rnd_ovf", ovf_err, 0);
    chk("rnd_proto", proto_err, 0);

    // Single-flit packet on VC1.
    do_reset();
    ej.out_ready = 1'b1;
    wr(1, 1, 1, 32'hA1);
    #2;
    chk("t1_valid", ej.out_valid, 1);
    chk("t1_vc", ej.out_vc, 1);
    cyc();
    chk("t1_credit", credit_out, 4'b0010);
    cyc();
    chk("t1_credit_off", credit_out, 4'b0000);

    // Interleaved 3-flit packets on VC0 and VC2.
    do_reset();
    ej.out_ready = 1'b1;
    wr(0, 1, 0, 32'h10); wr(2, 1, 0, 32'h20);
    wr(0, 0, 0, 32'h11); wr(2, 0, 0, 32'h21);
    wr(0, 0, 1, 32'h12); wr(2, 0, 1, 32'h22);
    repeat (10) cyc();
    chk("t2_count", log_vc.size(), 6);
    if (log_vc.size() == 6) begin
      chk("t2_seq0", {log_vc[0], log_pay[0]}, {32'd0, 32'h10});
      chk("t2_seq1", {log_vc[1], log_pay[1]}, {32'd0, 32'h11});
      chk("t2_seq2", {log_vc[2], log_pay[2]}, {32'd0, 32'h12});
      chk("t2_seq3", {log_vc[3], log_pay[3]}, {32'd2, 32'h20});
      chk("t2_seq4", {log_vc[4], log_pay[4]}, {32'd2, 32'h21});
      chk("t2_seq5", {log_vc[5], log_pay[5]}, {32'd2, 32'h22});
    end
    chk("t2_credits", dut_crd_cnt, 6);

    // Overflow on VC3.
    do_reset();
    wr(3, 1, 0, 32'h30); wr(3, 0, 0, 32'h31);
    wr(3, 0, 0, 32'h32); wr(3, 0, 0, 32'h33);
    chk("t3_no_ovf", ovf_err, 0);
    wr(3, 0, 1, 32'h34);
    chk("t3_ovf", ovf_err, 1);
    ej.out_ready = 1'b1;
    repeat (8) cyc();
    chk("t3_count", log_vc.size(), 4);
    if (log_vc.size() == 4) chk("t3_last", log_pay[3], 32'h33);
    chk("t3_credits", dut_crd_cnt, 4);

    // Round-robin order with pointer wrap.
    do_reset();
    wr(0, 1, 1, 32'h40); wr(1, 1, 1, 32'h41); wr(2, 1, 1, 32'h42);
    ej.out_ready = 1'b1;
    repeat (5) cyc();
    ej.out_ready = 1'b0;
    wr(2, 1, 1, 32'h52); wr(0, 1, 1, 32'h50);
    ej.out_ready = 1'b1;
    repeat (4) cyc();
    chk("t4_count", log_vc.size(), 5);
    if (log_vc.size() == 5) begin
      chk("t4_g0", log_vc[0], 0);
      chk("t4_g1", log_vc[1], 1);
      chk("t4_g2", log_vc[2], 2);
      chk("t4_g3", log_vc[3], 0);
      chk("t4_g4", log_vc[4], 2);
    end

    // Body flit on idle VC1.
    do_reset();
    ej.out_ready = 1'b1;
    wr(1, 0, 0, 32'h77);
    chk("t5_proto", proto_err, 1);
    repeat (5) cyc();
    chk("t5_none", log_vc.size(), 0);
    chk("t5_valid", ej.out_valid, 0);

    // Reset while locked mid-packet on VC2.
    do_reset();
    ej.out_ready = 1'b1;
    wr(2, 1, 0, 32'h60);
    cyc();
    ej.out_ready = 1'b0;
    wr(2, 0, 0, 32'h61);
    chk("t6_locked_valid", ej.out_valid, 1);
    chk("t6_locked_vc", ej.out_vc, 2);
    reset = 1'b0;
    #1;
    chk("t6_rst_valid", ej.out_valid, 0);
    chk("t6_rst_credit", credit_out, 0);
    cyc(); cyc();
    reset = 1'b1;
    cyc();
    ej.out_ready = 1'b1;
    wr(2, 1, 1, 32'h62);
    repeat (3) cyc();
    chk("t6_count", log_vc.size(), 1);
    if (log_vc.size() == 1) chk("t6_pay", log_pay[0], 32'h62);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
